// File: rtl/bitonic_merge_network_8_pkg.sv
// Shared types and constants for the merger-tree node: lane geometry, tuple
// and sideband types, and lane extraction.
package bitonic_merge_network_8_pkg;

    localparam int LANES   = 4;
    localparam int ELEM_W  = 32;
    localparam int TUPLE_W = LANES * ELEM_W;
    localparam int NET_N   = 2 * LANES;

    typedef logic [ELEM_W-1:0]  key_t;
    typedef logic [TUPLE_W-1:0] tuple_t;

    typedef struct packed {
        tuple_t top_tuple;
        logic   switch_output;
        logic   stall;
    } sideband_t;

    // A flushed slot is a bubble: stall set, everything else cleared.
    localparam sideband_t SIDEBAND_RST = '{top_tuple: '0, switch_output: 1'b0, stall: 1'b1};

    function automatic key_t get_lane(input tuple_t t, input int unsigned k);
        return t[k*ELEM_W +: ELEM_W];
    endfunction

endpackage

// File: rtl/bitonic_merge_network_8_if.sv
// Tuple-pair bus of the bitonic merge network: inputs, sideband and results.
interface bitonic_merge_network_8_if
    import bitonic_merge_network_8_pkg::*;
#(
    parameter int DATA_WIDTH = TUPLE_W
);
    logic [DATA_WIDTH-1:0] i_elems_0;
    logic [DATA_WIDTH-1:0] i_elems_1;
    logic [DATA_WIDTH-1:0] top_tuple;
    logic                  switch_output;
    logic                  stall;
    logic [DATA_WIDTH-1:0] o_elems_0;
    logic [DATA_WIDTH-1:0] o_elems_1;
    logic [DATA_WIDTH-1:0] o_top_tuple;
    logic                  o_switch_output;
    logic                  o_stall;

    modport master (
        output i_elems_0, i_elems_1, top_tuple, switch_output, stall,
        input  o_elems_0, o_elems_1, o_top_tuple, o_switch_output, o_stall
    );

    modport slave (
        input  i_elems_0, i_elems_1, top_tuple, switch_output, stall,
        output o_elems_0, o_elems_1, o_top_tuple, o_switch_output, o_stall
    );

endinterface

// File: rtl/bitonic_merge_network_8_cas_unit.sv
// Combinational unsigned compare-exchange: smaller key to min_key, larger to max_key.
module cas_unit
    import bitonic_merge_network_8_pkg::*;
(
    input  key_t a,
    input  key_t b,
    output key_t min_key,
    output key_t max_key
);
    logic swap;

    assign swap    = (a > b);
    assign min_key = swap ? b : a;
    assign max_key = swap ? a : b;

endmodule

// File: rtl/bitonic_merge_network_8.sv
// Three-stage pipelined bitonic merger of two ascending 4-key tuples, with the
// sideband delayed alongside so cascaded nodes stay slot-aligned.
module bitonic_merge_network_8
    import bitonic_merge_network_8_pkg::*;
#(
    parameter int DATA_WIDTH = TUPLE_W
)
(
    input  logic                     i_clk,
    input  logic                     i_rst,
    bitonic_merge_network_8_if.slave bus
);
    localparam int LANE_W = DATA_WIDTH / LANES;

    key_t      v0      [NET_N];
    key_t      s1_next [NET_N];
    key_t      s1_reg  [NET_N];
    key_t      s2_next [NET_N];
    key_t      s2_reg  [NET_N];
    key_t      s3_next [NET_N];
    key_t      s3_reg  [NET_N];
    sideband_t sb0;
    sideband_t sb1_reg;
    sideband_t sb2_reg;
    sideband_t sb3_reg;
    logic [DATA_WIDTH-1:0] out_lo;
    logic [DATA_WIDTH-1:0] out_hi;

    // B is placed reversed behind A so the 8-vector is bitonic.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_stage0
            assign v0[gi]         = get_lane(bus.i_elems_0, gi);
            assign v0[NET_N-1-gi] = get_lane(bus.i_elems_1, gi);
        end

        for (gi = 0; gi < LANES; gi++) begin : g_stage1
            cas_unit u_cas (
                .a       (v0[gi]),
                .b       (v0[gi+4]),
                .min_key (s1_next[gi]),
                .max_key (s1_next[gi+4])
            );
        end

        for (gi = 0; gi < LANES; gi++) begin : g_stage2
            localparam int LO = (gi / 2) * 4 + (gi % 2);
            cas_unit u_cas (
                .a       (s1_reg[LO]),
                .b       (s1_reg[LO+2]),
                .min_key (s2_next[LO]),
                .max_key (s2_next[LO+2])
            );
        end

        for (gi = 0; gi < LANES; gi++) begin : g_stage3
            cas_unit u_cas (
                .a       (s2_reg[2*gi]),
                .b       (s2_reg[2*gi+1]),
                .min_key (s3_next[2*gi]),
                .max_key (s3_next[2*gi+1])
            );
        end
    endgenerate

    assign sb0 = '{top_tuple: bus.top_tuple, switch_output: bus.switch_output, stall: bus.stall};

    // Never frozen: stall is carried as data, reset flushes every slot to a bubble.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < NET_N; k++) begin
                s1_reg[k] <= '0;
                s2_reg[k] <= '0;
                s3_reg[k] <= '0;
            end
            sb1_reg <= SIDEBAND_RST;
            sb2_reg <= SIDEBAND_RST;
            sb3_reg <= SIDEBAND_RST;
        end else begin
            s1_reg  <= s1_next;
            s2_reg  <= s2_next;
            s3_reg  <= s3_next;
            sb1_reg <= sb0;
            sb2_reg <= sb1_reg;
            sb3_reg <= sb2_reg;
        end
    end

    always_comb begin
        out_lo = '0;
        out_hi = '0;
        for (int k = 0; k < LANES; k++) begin
            out_lo[k*LANE_W +: LANE_W] = s3_reg[k];
            out_hi[k*LANE_W +: LANE_W] = s3_reg[k+LANES];
        end
    end

    assign bus.o_elems_0       = out_lo;
    assign bus.o_elems_1       = out_hi;
    assign bus.o_top_tuple     = sb3_reg.top_tuple;
    assign bus.o_switch_output = sb3_reg.switch_output;
    assign bus.o_stall         = sb3_reg.stall;

endmodule

// File: tb/tb_bitonic_merge_network_8.sv
// Scoreboard bench for bitonic_merge_network_8: directed table, sideband
// alignment, mid-stream reset and random sorted traffic.
module tb_bitonic_merge_network_8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    bitonic_merge_network_8_if bus ();

    bitonic_merge_network_8 dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [127:0] e0;
        logic [127:0] e1;
        logic [127:0] top;
        logic         sw;
        logic         stall;
    } exp_t;

    typedef struct {
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] e0;
        logic [127:0] e1;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[4];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   slot_idx = 0;

    function automatic logic [127:0] pack4(input logic [31:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic void ref_merge(input logic [127:0] a, b,
                                      output logic [127:0] e0, e1);
        logic [31:0] k [8];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) begin
            k[i]   = a[i*32 +: 32];
            k[i+4] = b[i*32 +: 32];
        end
        for (int i = 1; i < 8; i++) begin
            for (int j = i; j > 0; j--) begin
                if (k[j-1] > k[j]) begin
                    t      = k[j];
                    k[j]   = k[j-1];
                    k[j-1] = t;
                end
            end
        end
        e0 = pack4(k[0], k[1], k[2], k[3]);
        e1 = pack4(k[4], k[5], k[6], k[7]);
    endfunction

    function automatic logic [127:0] rand_sorted();
        logic [31:0] k [4];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 7))
                0:       k[i] = 32'h0;
                1:       k[i] = 32'hFFFF_FFFF;
                2:       k[i] = 32'(($urandom_range(0, 3)));
                default: k[i] = $urandom;
            endcase
        end
        for (int i = 1; i < 4; i++) begin
            for (int j = i; j > 0; j--) begin
                if (k[j-1] > k[j]) begin
                    t      = k[j];
                    k[j]   = k[j-1];
                    k[j-1] = t;
                end
            end
        end
        return pack4(k[0], k[1], k[2], k[3]);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL slot %0d %s: got %h expected %h", slot_idx, name, act, req);
        end
    endtask

    task automatic push_reset_slots();
        exp_t r;
        r.e0 = '0; r.e1 = '0; r.top = '0; r.sw = 1'b0; r.stall = 1'b1;
        sb_q.delete();
        for (int i = 0; i < 3; i++) sb_q.push_back(r);
    endtask

    // One cycle: compare the result due now, then drive the next slot.
    task automatic slot(input logic [127:0] a, b, top, input logic sw, st,
                        input bit use_exp, input logic [127:0] x0, x1, input bit do_rst);
        exp_t e;
        @(negedge clk);
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL slot %0d scoreboard: got empty queue expected 3 entries", slot_idx);
        end else begin
            e = sb_q.pop_front();
            check("o_stall", {127'b0, bus.o_stall}, {127'b0, e.stall});
            check("o_switch_output", {127'b0, bus.o_switch_output}, {127'b0, e.sw});
            check("o_top_tuple", bus.o_top_tuple, e.top);
            check("o_elems_0", bus.o_elems_0, e.e0);
            check("o_elems_1", bus.o_elems_1, e.e1);
            $display("slot %0d: stall=%b sw=%b top=%h e0=%h e1=%h", slot_idx,
                     bus.o_stall, bus.o_switch_output, bus.o_top_tuple,
                     bus.o_elems_0, bus.o_elems_1);
        end
        slot_idx++;
        rst               = do_rst;
        bus.i_elems_0     = a;
        bus.i_elems_1     = b;
        bus.top_tuple     = top;
        bus.switch_output = sw;
        bus.stall         = st;
        if (do_rst) begin
            push_reset_slots();
        end else begin
            e.top   = top;
            e.sw    = sw;
            e.stall = st;
            if (use_exp) begin
                e.e0 = x0;
                e.e1 = x1;
            end else begin
                ref_merge(a, b, e.e0, e.e1);
            end
            sb_q.push_back(e);
        end
    endtask

    logic [127:0] ra, rb;
    logic [127:0] dummy;

    initial begin
        vecs[0] = '{a: pack4(1, 2, 3, 4), b: pack4(5, 6, 7, 8),
                    e0: pack4(1, 2, 3, 4), e1: pack4(5, 6, 7, 8)};
        vecs[1] = '{a: pack4(1, 3, 5, 7), b: pack4(2, 4, 6, 8),
                    e0: pack4(1, 2, 3, 4), e1: pack4(5, 6, 7, 8)};
        vecs[2] = '{a: pack4(9, 9, 10, 11), b: pack4(0, 0, 9, 12),
                    e0: pack4(0, 0, 9, 9), e1: pack4(9, 10, 11, 12)};
        vecs[3] = '{a: {128{1'b1}}, b: '0, e0: '0, e1: {128{1'b1}}};
        dummy = '0;

        rst               = 1'b1;
        bus.i_elems_0     = '0;
        bus.i_elems_1     = '0;
        bus.top_tuple     = '0;
        bus.switch_output = 1'b0;
        bus.stall         = 1'b1;
        @(negedge clk);
        @(negedge clk);
        push_reset_slots();

        // Directed vectors with hand-derived results
        for (int i = 0; i < 4; i++)
            slot(vecs[i].a, vecs[i].b, 128'(i + 100), 1'b0, 1'b0, 1'b1, vecs[i].e0, vecs[i].e1, 1'b0);

        // Sideband alignment: stall 0,1,0,0,1,0, toggling switch, top = index
        for (int i = 0; i < 6; i++) begin
            ra = rand_sorted();
            rb = rand_sorted();
            slot(ra, rb, 128'(i), 1'(i % 2), 1'((i == 1) || (i == 4)), 1'b0, dummy, dummy, 1'b0);
        end

        // Reset while three valid slots are in flight
        for (int i = 0; i < 3; i++) begin
            ra = rand_sorted();
            rb = rand_sorted();
            slot(ra, rb, 128'(200 + i), 1'b1, 1'b0, 1'b0, dummy, dummy, 1'b0);
        end
        slot(vecs[1].a, vecs[1].b, 128'hDEAD, 1'b1, 1'b0, 1'b0, dummy, dummy, 1'b1);
        slot(vecs[2].a, vecs[2].b, 128'hBEEF, 1'b1, 1'b0, 1'b1, vecs[2].e0, vecs[2].e1, 1'b0);
        for (int i = 0; i < 3; i++)
            slot('0, '0, '0, 1'b0, 1'b1, 1'b0, dummy, dummy, 1'b0);

        // Random back-to-back traffic with mixed stall/switch
        for (int i = 0; i < 24; i++) begin
            ra = rand_sorted();
            rb = rand_sorted();
            slot(ra, rb, {$urandom, $urandom, $urandom, $urandom},
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, dummy, dummy, 1'b0);
        end

        // Drain
        for (int i = 0; i < 3; i++)
            slot('0, '0, '0, 1'b0, 1'b1, 1'b0, dummy, dummy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
